psg_bus_seq: RTL and testbench

PSG_BUS_SEQ -- requirements
Module: psg_bus_seq

---
 rtl/psg_bus_seq_pkg.sv | 35 +++
 rtl/psg_bus_seq_arb.sv | 30 +++
 rtl/psg_bus_seq.sv | 159 +++++++++++++++
 tb/tb_psg_bus_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_bus_seq_pkg.sv
// Shared types for the PSG bus sequencer: FSM state encoding, requester id,
// and the bdir/bc1 pairs driven in each bus phase.
package psg_bus_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_GAP  = 3'd4
    } psg_state_t;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_STR = 1'b1
    } psg_src_t;

    // {bdir, bc1}
    localparam logic [1:0] BUS_INACT = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_ADDR  = 2'b11;

    function automatic logic [1:0] bus_ctl(input psg_state_t s);
        logic [1:0] ctl;
        case (s)
            ST_ADDR: ctl = BUS_ADDR;
            ST_WR:   ctl = BUS_WRITE;
            ST_RD:   ctl = BUS_READ;
            default: ctl = BUS_INACT;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/psg_bus_seq_arb.sv
// Two-requester round-robin arbiter; the last-grant flag resets to the stream
// side so the CPU wins the first contended grant.
module psg_bus_seq_arb
    import psg_bus_seq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_str,
    input  logic take,
    output logic gnt_cpu,
    output logic gnt_str
);

    psg_src_t last_grant;

    always_comb begin
        gnt_cpu = req_cpu & (~req_str | (last_grant == SRC_STR));
        gnt_str = req_str & (~req_cpu | (last_grant == SRC_CPU));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= SRC_STR;
        end else if (take) begin
            last_grant <= gnt_str ? SRC_STR : SRC_CPU;
        end
    end

endmodule

// File: rtl/psg_bus_seq.sv
// PSG bus sequencer: arbitrates CPU and register-stream requests and plays
// ADDR / WR|RD / GAP phases on the bdir/bc1/d bus, advancing only on ce.
//
// state | meaning
// IDLE  | bus inactive, grant a pending request on a ce cycle
// ADDR  | latch address {ADDRMASK, reg} into the PSG
// WR    | drive write data
// RD    | PSG drives q, sampled into cpu_rq on exit
// GAP   | IDLE_CE inactive ce cycles before the next grant
module psg_bus_seq
    import psg_bus_seq_pkg::*;
#(
    parameter logic [3:0] ADDRMASK = 4'b0000,
    parameter int         IDLE_CE  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       cpu_req,
    input  logic       cpu_rd,
    input  logic [3:0] cpu_reg,
    input  logic [7:0] cpu_wd,
    output logic       cpu_ack,
    output logic [7:0] cpu_rq,
    input  logic       str_valid,
    input  logic [3:0] str_reg,
    input  logic [7:0] str_wd,
    output logic       str_ready,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] d,
    input  logic [7:0] q,
    output logic       busy
);

    localparam int GW = (IDLE_CE > 2) ? $clog2(IDLE_CE) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (IDLE_CE > 0) ? GW'(IDLE_CE - 1) : '0;
    localparam psg_state_t POST_XFER = (IDLE_CE > 0) ? ST_GAP : ST_IDLE;

    psg_state_t state, state_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    psg_src_t   txn_src, src_nx;
    logic       txn_rd, rd_nx;
    logic [3:0] txn_reg, reg_nx;
    logic [7:0] txn_wd, wd_nx;
    logic [7:0] rq_nx, d_nx;
    logic [1:0] ctl_nx;
    logic       ack_cpu_nx, ack_str_nx;
    logic       take, gnt_cpu, gnt_str;

    psg_bus_seq_arb u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_cpu (cpu_req),
        .req_str (str_valid),
        .take    (take),
        .gnt_cpu (gnt_cpu),
        .gnt_str (gnt_str)
    );

    always_comb begin
        state_nx   = state;
        gap_nx     = gap_cnt;
        src_nx     = txn_src;
        rd_nx      = txn_rd;
        reg_nx     = txn_reg;
        wd_nx      = txn_wd;
        rq_nx      = cpu_rq;
        ack_cpu_nx = 1'b0;
        ack_str_nx = 1'b0;
        take       = 1'b0;

        if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (gnt_cpu || gnt_str) begin
                        take     = 1'b1;
                        state_nx = ST_ADDR;
                        if (gnt_cpu) begin
                            src_nx = SRC_CPU;
                            rd_nx  = cpu_rd;
                            reg_nx = cpu_reg;
                            wd_nx  = cpu_wd;
                        end else begin
                            // stream side is write-only
                            src_nx = SRC_STR;
                            rd_nx  = 1'b0;
                            reg_nx = str_reg;
                            wd_nx  = str_wd;
                        end
                    end
                end
                ST_ADDR: state_nx = txn_rd ? ST_RD : ST_WR;
                ST_WR: begin
                    ack_cpu_nx = (txn_src == SRC_CPU);
                    ack_str_nx = (txn_src == SRC_STR);
                    gap_nx     = GAP_LOAD;
                    state_nx   = POST_XFER;
                end
                ST_RD: begin
                    rq_nx      = q;
                    ack_cpu_nx = (txn_src == SRC_CPU);
                    ack_str_nx = (txn_src == SRC_STR);
                    gap_nx     = GAP_LOAD;
                    state_nx   = POST_XFER;
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        gap_nx = gap_cnt - 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        // bus outputs follow the state being entered so they stay registered
        ctl_nx = bus_ctl(state_nx);
        case (state_nx)
            ST_ADDR: d_nx = {ADDRMASK, reg_nx};
            ST_WR:   d_nx = wd_nx;
            default: d_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            txn_src   <= SRC_CPU;
            txn_rd    <= 1'b0;
            txn_reg   <= 4'h0;
            txn_wd    <= 8'h00;
            cpu_rq    <= 8'h00;
            cpu_ack   <= 1'b0;
            str_ready <= 1'b0;
            bdir      <= 1'b0;
            bc1       <= 1'b0;
            d         <= 8'h00;
        end else begin
            state     <= state_nx;
            gap_cnt   <= gap_nx;
            txn_src   <= src_nx;
            txn_rd    <= rd_nx;
            txn_reg   <= reg_nx;
            txn_wd    <= wd_nx;
            cpu_rq    <= rq_nx;
            cpu_ack   <= ack_cpu_nx;
            str_ready <= ack_str_nx;
            bdir      <= ctl_nx[1];
            bc1       <= ctl_nx[0];
            d         <= d_nx;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_psg_bus_seq.sv
// Bench for psg_bus_seq: per-scenario tasks with inline phase checks plus a
// transaction scoreboard popped on every cpu_ack / str_ready pulse.
module tb_psg_bus_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b1;
    logic       cpu_req = 1'b0, cpu_rd = 1'b0, str_valid = 1'b0;
    logic [3:0] cpu_reg = 4'h0, str_reg = 4'h0;
    logic [7:0] cpu_wd = 8'h00, str_wd = 8'h00, q = 8'h00;
    logic       cpu_ack, str_ready, bdir, bc1, busy;
    logic [7:0] cpu_rq, d;

    int n_cmp = 0;
    int n_err = 0;
    bit ce_slow = 1'b0;
    bit ce_hold = 1'b0;
    int ce_ph = 0;

    typedef struct {
        bit         src;
        bit         rd;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mon_addr = 8'h00, mon_wd = 8'h00;

    psg_bus_seq dut (
        .clock(clock), .reset(reset), .ce(ce),
        .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_reg(cpu_reg), .cpu_wd(cpu_wd),
        .cpu_ack(cpu_ack), .cpu_rq(cpu_rq),
        .str_valid(str_valid), .str_reg(str_reg), .str_wd(str_wd), .str_ready(str_ready),
        .bdir(bdir), .bc1(bc1), .d(d), .q(q), .busy(busy)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(negedge clock);
        if (ce_hold) ce = 1'b0;
        else if (ce_slow) begin
            ce_ph = (ce_ph + 1) % 4;
            ce = (ce_ph == 0);
        end else ce = 1'b1;
    end

    // scoreboard monitor
    initial forever begin
        exp_t e;
        logic [7:0] got;
        @(posedge clock); #1;
        if (bdir && bc1)  mon_addr = d;
        if (bdir && !bc1) mon_wd = d;
        if (cpu_ack || str_ready) begin
            n_cmp++;
            if (cpu_ack && str_ready) begin
                n_err++;
                $display("FAIL ack_overlap: cpu_ack=%b str_ready=%b, required at most one high", cpu_ack, str_ready);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: cpu_ack=%b str_ready=%b at %0t, required no ack", cpu_ack, str_ready, $time);
            end else begin
                e = sb.pop_front();
                got = e.rd ? cpu_rq : mon_wd;
                if ({str_ready, mon_addr, got} !== {e.src, e.addr, e.data}) begin
                    n_err++;
                    $display("FAIL sb_txn: src=%b addr=%h data=%h, required src=%b addr=%h data=%h",
                             str_ready, mon_addr, got, e.src, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; str_valid = 1'b1; q = 8'hFF;
        repeat (3) tick();
        n_cmp++;
        if ({bdir, bc1, d, cpu_rq, cpu_ack, str_ready, busy} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_outputs: bdir=%b bc1=%b d=%h rq=%h ack=%b rdy=%b busy=%b, required all 0",
                     bdir, bc1, d, cpu_rq, cpu_ack, str_ready, busy);
        end
        cpu_req = 1'b0; str_valid = 1'b0; q = 8'h00;
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_cpu_write();
        logic [12:0] exp [5];
        exp = '{{2'b11, 8'h07, 3'b001}, {2'b10, 8'h38, 3'b001}, {2'b00, 8'h00, 3'b101},
                {2'b00, 8'h00, 3'b000}, {2'b00, 8'h00, 3'b000}};
        tick();
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h7; cpu_wd = 8'h38;
        sb.push_back('{1'b0, 1'b0, 8'h07, 8'h38});
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({bdir, bc1, d, cpu_ack, str_ready, busy} !== exp[i]) begin
                n_err++;
                $display("FAIL cpu_write_c%0d: bdir,bc1,d,ack,rdy,busy=%b, required %b", i,
                         {bdir, bc1, d, cpu_ack, str_ready, busy}, exp[i]);
            end
            if (i == 0) begin cpu_reg = 4'hF; cpu_wd = 8'hFF; end
            if (i == 2) cpu_req = 1'b0;
        end
    endtask

    task automatic test_cpu_read();
        logic [12:0] exp [4];
        bit got;
        exp = '{{2'b11, 8'h08, 3'b001}, {2'b01, 8'h00, 3'b001},
                {2'b00, 8'h00, 3'b101}, {2'b00, 8'h00, 3'b000}};
        tick();
        q = 8'h1F; cpu_req = 1'b1; cpu_rd = 1'b1; cpu_reg = 4'h8;
        sb.push_back('{1'b0, 1'b1, 8'h08, 8'h1F});
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bdir, bc1, d, cpu_ack, str_ready, busy} !== exp[i]) begin
                n_err++;
                $display("FAIL cpu_read_c%0d: bdir,bc1,d,ack,rdy,busy=%b, required %b", i,
                         {bdir, bc1, d, cpu_ack, str_ready, busy}, exp[i]);
            end
            if (i == 2) begin cpu_req = 1'b0; q = 8'h00; end
        end
        // cpu_rq must hold across a following write
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h1; cpu_wd = 8'hAA;
        sb.push_back('{1'b0, 1'b0, 8'h01, 8'hAA});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        n_cmp++;
        if (!got || cpu_rq !== 8'h1F) begin
            n_err++;
            $display("FAIL rq_hold: ack_seen=%b cpu_rq=%h, required ack_seen=1 cpu_rq=1f", got, cpu_rq);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last_t = 0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h1; cpu_wd = 8'h11;
        str_valid = 1'b1; str_reg = 4'h2; str_wd = 8'h22;
        sb.delete();
        for (int i = 0; i < 4; i++)
            if (i % 2 == 0) sb.push_back('{1'b0, 1'b0, 8'h01, 8'h11});
            else            sb.push_back('{1'b1, 1'b0, 8'h02, 8'h22});
        repeat (2) tick();
        reset = 1'b1;
        for (int t = 0; t < 60 && n < 4; t++) begin
            tick();
            if (cpu_ack || str_ready) begin
                n_cmp++;
                if (str_ready !== (n % 2 == 1)) begin
                    n_err++;
                    $display("FAIL rr_order_%0d: str_ready=%b, required %b", n, str_ready, (n % 2 == 1));
                end
                if (n > 0) begin
                    n_cmp++;
                    if (t - last_t != 4) begin
                        n_err++;
                        $display("FAIL rr_spacing_%0d: %0d clocks, required 4", n, t - last_t);
                    end
                end
                last_t = t;
                n++;
                if (n == 4) begin cpu_req = 1'b0; str_valid = 1'b0; end
            end
        end
        cpu_req = 1'b0; str_valid = 1'b0;
        n_cmp++;
        if (n != 4) begin
            n_err++;
            $display("FAIL rr_timeout: %0d acks, required 4", n);
        end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        int wr_cnt = 0, gap = 0, rdy = 0, addr_t0 = -1, addr_t1 = -1;
        logic [1:0] prev = 2'b00;
        tick();
        str_valid = 1'b1; str_reg = 4'hD; str_wd = 8'h05;
        sb.push_back('{1'b1, 1'b0, 8'h0D, 8'h05});
        sb.push_back('{1'b1, 1'b0, 8'h0D, 8'h0A});
        for (int t = 0; t < 40 && rdy < 2; t++) begin
            tick();
            if ({bdir, bc1} == 2'b11 && prev != 2'b11) begin
                if (addr_t0 < 0) begin addr_t0 = t; str_wd = 8'h0A; end
                else addr_t1 = t;
            end
            if ({bdir, bc1} == 2'b10 && prev != 2'b10) wr_cnt++;
            if (wr_cnt == 1 && !bdir) gap++;
            if (str_ready) begin
                rdy++;
                if (rdy == 2) str_valid = 1'b0;
            end
            prev = {bdir, bc1};
        end
        str_valid = 1'b0;
        n_cmp++;
        if (wr_cnt != 2 || gap < 1) begin
            n_err++;
            $display("FAIL b2b_r13: wr_phases=%0d bdir0_gap=%0d, required 2 and >=1", wr_cnt, gap);
        end
        n_cmp++;
        if (addr_t1 - addr_t0 != 4) begin
            n_err++;
            $display("FAIL b2b_grant_spacing: %0d clocks, required 4", addr_t1 - addr_t0);
        end
        repeat (3) tick();
    endtask

    task automatic test_ce_slow();
        int n_addr = 0, n_wr = 0, n_gap = 0, n_ack = 0;
        bit done = 1'b0;
        ce_slow = 1'b1;
        repeat (5) tick();
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h2; cpu_wd = 8'h5A;
        sb.push_back('{1'b0, 1'b0, 8'h02, 8'h5A});
        for (int t = 0; t < 80 && !done; t++) begin
            tick();
            if ({bdir, bc1} == 2'b11) n_addr++;
            if ({bdir, bc1} == 2'b10) n_wr++;
            if ({bdir, bc1} == 2'b00 && busy) n_gap++;
            if (cpu_ack) begin n_ack++; cpu_req = 1'b0; end
            if (n_ack > 0 && !busy) done = 1'b1;
        end
        n_cmp++;
        if (n_addr != 4 || n_wr != 4 || n_gap != 4 || n_ack != 1 || !done) begin
            n_err++;
            $display("FAIL ce_div4: addr=%0d wr=%0d gap=%0d ack=%0d done=%b, required 4 4 4 1 1",
                     n_addr, n_wr, n_gap, n_ack, done);
        end
        cpu_req = 1'b0;
        ce_slow = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_drop_and_freeze();
        bit bad = 1'b0;
        bit got = 1'b0;
        ce_hold = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h6; cpu_wd = 8'h3C;
        repeat (2) tick();
        cpu_req = 1'b0;
        ce_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || bdir || bc1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL drop_before_grant: bus activity seen=%b, required 0", bad);
        end
        cpu_req = 1'b1; cpu_reg = 4'h3; cpu_wd = 8'hC3;
        sb.push_back('{1'b0, 1'b0, 8'h03, 8'hC3});
        tick();
        ce_hold = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({bdir, bc1, d, busy, cpu_ack} !== {2'b11, 8'h03, 2'b10}) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL ce_freeze: bdir,bc1,d,busy,ack=%b, required %b",
                     {bdir, bc1, d, busy, cpu_ack}, {2'b11, 8'h03, 2'b10});
        end
        ce_hold = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL freeze_resume: ack_seen=%b, required 1", got);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bit in_wr = 1'b0;
        bit bad = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_rd = 1'b0; cpu_reg = 4'h4; cpu_wd = 8'h77;
        sb.push_back('{1'b0, 1'b0, 8'h04, 8'h77});
        for (int i = 0; i < 20 && !in_wr; i++) begin
            tick();
            if ({bdir, bc1} == 2'b10) in_wr = 1'b1;
        end
        n_cmp++;
        if (!in_wr) begin
            n_err++;
            $display("FAIL rstmid_reach_wr: in_wr=%b, required 1", in_wr);
        end
        #2 reset = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if ({bdir, bc1, d, cpu_ack, str_ready, busy} !== 13'h0) begin
            n_err++;
            $display("FAIL rstmid_async: bdir,bc1,d,ack,rdy,busy=%b, required 0",
                     {bdir, bc1, d, cpu_ack, str_ready, busy});
        end
        cpu_req = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || bdir || bc1 || cpu_ack || str_ready) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL rstmid_no_reissue: activity after release=%b, required 0", bad);
        end
        str_valid = 1'b1; str_reg = 4'h5; str_wd = 8'h99;
        sb.push_back('{1'b1, 1'b0, 8'h05, 8'h99});
        tick();
        n_cmp++;
        if ({bdir, bc1, d} !== {2'b11, 8'h05}) begin
            n_err++;
            $display("FAIL rstmid_restart_addr: bdir,bc1,d=%b, required %b", {bdir, bc1, d}, {2'b11, 8'h05});
        end
        tick();
        tick();
        str_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_round_robin();
        test_back_to_back();
        test_ce_slow();
        test_drop_and_freeze();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
